// File: rtl/bf_ins_pkg.sv
// Shared types and helpers for the field inserter: FSM state encoding,
// slot-index width calculation and slot-map entry extraction.
package bf_ins_pkg;

    // Assembly state: empty, partially filled, or holding a complete word
    // that still has to move into the output register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PEND = 2'd2
    } ins_state_e;

    // Widest slot map the extraction helper accepts.
    localparam int CFG_MAX_BITS = 256;

    // Bits needed to index n slots; a single slot still gets one bit.
    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry idx of a packed slot map whose entries are w bits wide.
    function automatic logic [31:0] cfg_entry(input logic [CFG_MAX_BITS-1:0] init,
                                              input int idx,
                                              input int w);
        logic [CFG_MAX_BITS-1:0] shifted;
        shifted = init >> (idx * w);
        return shifted[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/bf_slot_cfg_rom.sv
// Mode -> slot-index lookup. The table is a constant built from the packed
// slot map; the read is registered and only advances when en is high.
module bf_slot_cfg_rom
    import bf_ins_pkg::*;
#(
    parameter int MODE_WIDTH = 2,
    parameter int SLOT_IDX_W = 2,
    parameter int CFG_DEPTH  = 3,
    parameter logic [CFG_DEPTH*SLOT_IDX_W-1:0] INIT_FILE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [MODE_WIDTH-1:0] addr,
    output logic [SLOT_IDX_W-1:0] slot,
    output logic                  oor
);

    logic [SLOT_IDX_W-1:0] table_w [CFG_DEPTH];
    logic [SLOT_IDX_W-1:0] rd_slot;
    logic                  rd_oor;

    // NOTE: the table is constant wiring from the parameter, so it carries no
    // reset; only the read register below is reset.
    for (genvar g = 0; g < CFG_DEPTH; g++) begin : g_table
        assign table_w[g] = SLOT_IDX_W'(cfg_entry(CFG_MAX_BITS'(INIT_FILE), g, SLOT_IDX_W));
    end

    // Combinational table search; modes past the table flag out-of-range.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        rd_slot = '0;
        rd_oor  = 1'b1;
        for (int m = 0; m < CFG_DEPTH; m++) begin
            if (addr == MODE_WIDTH'(m)) begin
                rd_slot = table_w[m];
                rd_oor  = 1'b0;
            end
        end
    end

    // Registered read, held while the lookup stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state.
        if (!rst_n) begin
            slot <= '0;
            oor  <= 1'b0;
        end else if (en) begin
            slot <= rd_slot;
            oor  <= rd_oor;
        end
    end

endmodule

// File: rtl/bf_field_inserter.sv
// Field deposit engine: narrow fields tagged with a mode are placed into the
// slot the config ROM assigns, and complete words leave through a one-entry
// output register. Two stages: L (lookup) and A (assembly + output).
module bf_field_inserter
    import bf_ins_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MODE_WIDTH = 2,
    parameter int N_NUM      = 4,
    parameter int SLOT_WIDTH = DATA_WIDTH / N_NUM,
    parameter int SLOT_IDX_W = slot_idx_w(N_NUM),
    parameter int CFG_DEPTH  = 3,
    parameter logic [CFG_DEPTH*SLOT_IDX_W-1:0] INIT_FILE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MODE_WIDTH-1:0] mode_i,
    input  logic                  dval_i,
    input  logic [SLOT_WIDTH-1:0] field_i,
    input  logic                  last_i,
    output logic                  rdy_o,
    output logic                  dval_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [N_NUM-1:0]      mask_o,
    input  logic                  ready_i,
    output logic                  err_o
);

    // Stage L
    logic                  v1;
    logic                  l1;
    logic [SLOT_WIDTH-1:0] f1;
    logic [SLOT_IDX_W-1:0] slot1;
    logic                  bad1;

    // Stage A
    ins_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] asm_data_q, asm_data_d;
    logic [N_NUM-1:0]      asm_mask_q, asm_mask_d;
    logic                  out_load;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [N_NUM-1:0]      out_mask_d;
    logic                  err_d;

    logic                  out_free;
    logic                  take;
    logic                  accept;
    logic [N_NUM-1:0]      slot_bit;
    logic [N_NUM-1:0]      merged_mask;
    logic [DATA_WIDTH-1:0] field_word;
    logic [DATA_WIDTH-1:0] merged_data;

    // The output register can take a word if empty or being drained now.
    assign out_free = !dval_o || ready_i;
    // Stage A consumes the L entry unless a pending word blocks it.
    assign take     = v1 && (state_q != ST_PEND) && out_free;
    assign rdy_o    = !v1 || take;
    assign accept   = dval_i && rdy_o;

    // Field positioned in its slot; unfilled asm slots are zero, so OR merges.
    assign slot_bit    = N_NUM'(1) << slot1;
    assign field_word  = {{(DATA_WIDTH-SLOT_WIDTH){1'b0}}, f1} << (int'(slot1) * SLOT_WIDTH);
    assign merged_mask = asm_mask_q | slot_bit;
    assign merged_data = asm_data_q | field_word;

    bf_slot_cfg_rom #(
        .MODE_WIDTH (MODE_WIDTH),
        .SLOT_IDX_W (SLOT_IDX_W),
        .CFG_DEPTH  (CFG_DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_cfg_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .addr  (mode_i),
        .slot  (slot1),
        .oor   (bad1)
    );

    // Lookup stage: capture the accepted field alongside the ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            f1 <= '0;
            l1 <= 1'b0;
        end else begin
            if (rdy_o) v1 <= dval_i;
            if (accept) begin
                f1 <= field_i;
                l1 <= last_i;
            end
        end
    end

    // Assembly decisions: merge, collide, drop, or flush a pending word.
    always_comb begin
        state_d    = state_q;
        asm_data_d = asm_data_q;
        asm_mask_d = asm_mask_q;
        out_load   = 1'b0;
        out_data_d = asm_data_q;
        out_mask_d = asm_mask_q;
        err_d      = 1'b0;

        if (state_q == ST_PEND) begin
            if (out_free) begin
                out_load   = 1'b1;
                asm_data_d = '0;
                asm_mask_d = '0;
                state_d    = ST_IDLE;
            end
        end else if (take) begin
            if (bad1) begin
                err_d = 1'b1;
                if (l1 && (asm_mask_q != '0)) begin
                    out_load   = 1'b1;
                    asm_data_d = '0;
                    asm_mask_d = '0;
                    state_d    = ST_IDLE;
                end
            end else if ((asm_mask_q & slot_bit) != '0) begin
                // Collision: ship what we have, restart with the new field.
                out_load   = 1'b1;
                asm_data_d = field_word;
                asm_mask_d = slot_bit;
                state_d    = l1 ? ST_PEND : ST_FILL;
            end else if (l1 || (&merged_mask)) begin
                out_load   = 1'b1;
                out_data_d = merged_data;
                out_mask_d = merged_mask;
                asm_data_d = '0;
                asm_mask_d = '0;
                state_d    = ST_IDLE;
            end else begin
                asm_data_d = merged_data;
                asm_mask_d = merged_mask;
                state_d    = ST_FILL;
            end
        end
    end

    // Assembly state, output register and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            asm_data_q <= '0;
            asm_mask_q <= '0;
            dval_o     <= 1'b0;
            data_o     <= '0;
            mask_o     <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_data_q <= asm_data_d;
            asm_mask_q <= asm_mask_d;
            err_o      <= err_d;
            if (out_load) begin
                dval_o <= 1'b1;
                data_o <= out_data_d;
                mask_o <= out_mask_d;
            end else if (ready_i) begin
                dval_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bf_field_inserter.sv
// Scoreboard bench for bf_field_inserter with slot map m0->0, m1->1, m2->3.
module tb_bf_field_inserter;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode_i;
    logic        dval_i;
    logic [3:0]  field_i;
    logic        last_i;
    logic        rdy_o;
    logic        dval_o;
    logic [15:0] data_o;
    logic [3:0]  mask_o;
    logic        ready_i;
    logic        err_o;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    err_cnt = 0;
    word_t exp_q[$];
    int    pop_edges[$];
    bit    drv_done;

    bf_field_inserter #(
        .DATA_WIDTH (16),
        .MODE_WIDTH (2),
        .N_NUM      (4),
        .CFG_DEPTH  (3),
        .INIT_FILE  (6'b11_01_00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode_i  (mode_i),
        .dval_i  (dval_i),
        .field_i (field_i),
        .last_i  (last_i),
        .rdy_o   (rdy_o),
        .dval_o  (dval_o),
        .data_o  (data_o),
        .mask_o  (mask_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one field (called at posedge+1); returns the edge it was taken on.
    task automatic send(input logic [3:0] f, input logic [1:0] m, input logic l,
                        output int acc_edge);
        bit hs;
        hs       = 1'b0;
        acc_edge = -1;
        dval_i   = 1'b1;
        field_i  = f;
        mode_i   = m;
        last_i   = l;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            hs = rdy_o;
            @(posedge clk);
            #1;
        end
        if (hs) acc_edge = cyc;
        else    check("send_timeout", 32'd0, 32'd1);
        dval_i = 1'b0;
        last_i = 1'b0;
    endtask

    // Wait (bounded) for every expected word to be consumed.
    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: compare presented words with the scoreboard head.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (err_o) err_cnt++;
            if (rst_n && dval_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data=%h mask=%b expected none", data_o, mask_o);
                end else begin
                    w = exp_q[0];
                    check("word_data", {16'h0, data_o}, {16'h0, w.data});
                    check("word_mask", {28'h0, mask_o}, {28'h0, w.mask});
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        pop_edges.push_back(cyc + 1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e0, p0, ec0;
        rst_n   = 1'b0;
        ready_i = 1'b1;
        dval_i  = 1'b0;
        field_i = '0;
        mode_i  = '0;
        last_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dval", dval_o, 0);
        check("rst_data", data_o, 0);
        check("rst_mask", mask_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1;
        step();
        check("rst_rdy", rdy_o, 1);

        // 1) A/m0, B/m1, C/m2+last -> C0BA / 1011, consumed two edges after C.
        exp_q.push_back('{16'hC0BA, 4'b1011});
        pop_edges.delete();
        send(4'hA, 2'd0, 1'b0, e);
        send(4'hB, 2'd1, 1'b0, e);
        send(4'hC, 2'd2, 1'b1, e);
        drain();
        check("t1_latency", pop_edges.size() > 0 ? pop_edges[0] - e : -1, 2);

        // 2) Collision with last: 0001/0001 then 0002/0001 back to back.
        exp_q.push_back('{16'h0001, 4'b0001});
        exp_q.push_back('{16'h0002, 4'b0001});
        pop_edges.delete();
        send(4'h1, 2'd0, 1'b0, e);
        send(4'h2, 2'd0, 1'b1, e);
        drain();
        check("t2_first_latency", pop_edges.size() > 0 ? pop_edges[0] - e : -1, 2);
        check("t2_spacing", pop_edges.size() > 1 ? pop_edges[1] - pop_edges[0] : -1, 1);

        // 3) Backpressure: word held 5 cycles, later fields kept in order.
        exp_q.push_back('{16'hC0BA, 4'b1011});
        exp_q.push_back('{16'h0030, 4'b0010});
        exp_q.push_back('{16'h0004, 4'b0001});
        ready_i  = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                int de;
                send(4'hA, 2'd0, 1'b0, de);
                send(4'hB, 2'd1, 1'b0, de);
                send(4'hC, 2'd2, 1'b1, de);
                send(4'h3, 2'd1, 1'b1, de);
                send(4'h4, 2'd0, 1'b1, de);
                drv_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 20 && !dval_o; i++) step();
        check("t3_word_up", dval_o, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_dval", dval_o, 1);
            check("t3_rdy_low", rdy_o, 0);
            step();
        end
        ready_i = 1'b1;
        for (int i = 0; i < 60 && !drv_done; i++) step();
        check("t3_driver_done", drv_done, 1);
        drain();

        // 4) Good field then bad mode with last: one error, word 0005/0001.
        ec0 = err_cnt;
        exp_q.push_back('{16'h0005, 4'b0001});
        send(4'h5, 2'd0, 1'b0, e);
        send(4'h7, 2'd3, 1'b1, e);
        drain();
        repeat (3) step();
        check("t4_err_pulses", err_cnt - ec0, 1);

        // 5) Lone bad field with last: error pulse, no word.
        ec0 = err_cnt;
        p0  = pop_edges.size();
        send(4'h9, 2'd3, 1'b1, e);
        repeat (5) step();
        check("t5_err_pulses", err_cnt - ec0, 1);
        check("t5_no_word", pop_edges.size() - p0, 0);

        // 6) Reset mid-assembly discards the partial word.
        send(4'hA, 2'd0, 1'b0, e);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dval", dval_o, 0);
        check("t6_rst_data", data_o, 0);
        check("t6_rst_mask", mask_o, 0);
        check("t6_rst_err", err_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_rdy_after_rst", rdy_o, 1);
        p0 = pop_edges.size();
        exp_q.push_back('{16'h00E0, 4'b0010});
        send(4'hE, 2'd1, 1'b1, e);
        drain();
        repeat (5) step();
        check("t6_one_word", pop_edges.size() - p0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
